lvds_tx: RTL
============

Name: lvds_tx

Overview:
- Transmit counterpart of the modem LVDS I/Q receive path.
- Pulls 32-bit I/Q words from a TX FIFO and serializes each word MSB-first as 2 bits per i_ddr_clk cycle.
- Its o_ddr_data drives the D_OUT_1/D_OUT_0 pins of a DDR SB_IO on the o_iq_tx pair.
- One word takes 16 cycles. When no data is available, it emits an idle pattern without the sync bits.

Parameters:
- FORCE_SYNC, 1: when 1, overwrite word bits [31:30] with 2'b10 (I_SYNC) and bits [15:14] with 2'b01 (Q_SYNC); when 0, send the FIFO word verbatim.
- IDLE_WORD, 32'h0000_0000: word serialized when no FIFO word is fetched; sync forcing is never applied to it.

Ports:
- i_ddr_clk  input  1  DDR bit clock (global buffer); the only clock.
- i_rst_b  input  1  asynchronous reset, active-low.
- i_tx_enable  input  1  level; allows FIFO fetches; sampled only at the fetch point.
- i_fifo_empty  input  1  TX FIFO empty flag.
- o_fifo_pull  output  1  one-cycle read strobe to the FIFO.
- i_fifo_data  input  32  FIFO read data, valid the cycle after o_fifo_pull (registered read).
- o_ddr_data  output  2  [1] = rising-edge bit (earlier in time), [0] = falling-edge bit.
- o_word_strobe  output  1  one-cycle pulse in the first cycle a fetched word appears on o_ddr_data.
- o_underrun  output  1  one-cycle pulse when enabled but the FIFO is empty at the fetch point.
- o_busy  output  1  high while a fetched (non-idle) word is being shifted out.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-low (i_rst_b), on i_ddr_clk.
- Reset values: r_phase=0, shift=0, o_ddr_data=2'b00, o_fifo_pull=0, o_word_strobe=0, o_underrun=0, o_busy=0, fetch-pending=0.
- Reset mid-word: outputs go to their reset values immediately (asynchronously); the partial word is discarded and no FIFO pull is issued.
- Phase counter: 4-bit r_phase, free-running 0..15, wraps 15→0, so word boundaries have a fixed cadence. It increments every cycle out of reset, regardless of enable.
- Shifter: o_ddr_data = shift[31:30] (registered output). Each cycle, shift <= shift << 2, except at the phase 15→0 edge, which performs the load described below.
- Fetch point, phase 14 cycle:
  - If i_tx_enable=1 and i_fifo_empty=0: o_fifo_pull=1 for this cycle only, and fetch-pending is set.
  - If i_tx_enable=1 and i_fifo_empty=1: o_underrun=1 for this cycle, and no pull is issued.
  - If i_tx_enable=0: nothing happens.
- Load, clock edge ending the phase 15 cycle:
  - If fetch-pending: shift <= i_fifo_data with sync bits forced per FORCE_SYNC; o_word_strobe=1 and o_busy=1 in the following cycle (phase 0); fetch-pending is cleared.
  - Otherwise: shift <= IDLE_WORD and o_busy=0.
- Latency: a pull issued in the phase 14 cycle puts data bits [31:30] on o_ddr_data in the next phase 0 cycle, i.e. 2 cycles after the pull.
- Back-to-back words are gapless: bits [1:0] of word N are output in its phase 15 cycle, and bits [31:30] of word N+1 in the next cycle.
- o_busy stays high for all 16 cycles of a fetched word and drops at the next phase 0 only if no new word was loaded.
- Enable deasserted mid-word: the current word completes; the next fetch point issues no pull, and IDLE_WORD follows.
- Enable asserted mid-word: it takes effect at the next phase 14; no partial word is ever sent.
- FIFO empty deasserting after phase 14: the word waits for the next phase 14, and underrun was already flagged.
- FIFO empty and enable-low are independent: underrun is flagged only when enabled.
- Exactly one pull per 16 cycles, at most. A pull is never issued when i_fifo_empty=1.
- Bit order per word: I_SYNC(2), I[12:0], I control bit, Q_SYNC(2), Q[12:0], Q control bit. This mirrors the receive path word layout.

Test Plan:
- Reset release with enable=0: o_ddr_data=2'b00 continuously for 64 cycles; o_fifo_pull, o_busy and o_underrun never assert.
- Enable=1, FIFO preloaded with 32'h8001_4002:
  - Pull occurs at phase 14.
  - Starting 2 cycles later, o_ddr_data reads 10,00,…,01 then 01,00,…,10 (16 pairs reconstructing 32'h8001_4002).
  - o_word_strobe pulses once.
- FORCE_SYNC=1 with FIFO word 32'h0000_0000 → serialized word 32'h8000_4000; with FORCE_SYNC=0 → 32'h0000_0000 and o_busy still high for 16 cycles.
- Three queued words, enable held high:
  - Exactly 48 gapless cycles of data.
  - Pulls 16 cycles apart.
  - Then one o_underrun pulse at the next phase 14, followed by IDLE_WORD.
- Drop enable at phase 5 of a word: that word completes intact; no further pull; o_busy falls at the following phase 0.
- Assert i_rst_b=0 at phase 8 mid-word: o_ddr_data=00 immediately; after release, phase restarts at 0 and the first pull occurs at phase 14; the FIFO loses no extra word.

Source files
------------

// File: rtl/lvds_tx_if.sv
// FIFO-side handshake and serial output bundle of the LVDS I/Q transmitter.
// The DUT takes the slave modport; the FIFO/pin side takes the master modport.
interface lvds_tx_if;
    logic        i_tx_enable;
    logic        i_fifo_empty;
    logic        o_fifo_pull;
    logic [31:0] i_fifo_data;
    logic [1:0]  o_ddr_data;
    logic        o_word_strobe;
    logic        o_underrun;
    logic        o_busy;

    modport slave (
        input  i_tx_enable,
        input  i_fifo_empty,
        input  i_fifo_data,
        output o_fifo_pull,
        output o_ddr_data,
        output o_word_strobe,
        output o_underrun,
        output o_busy
    );

    modport master (
        output i_tx_enable,
        output i_fifo_empty,
        output i_fifo_data,
        input  o_fifo_pull,
        input  o_ddr_data,
        input  o_word_strobe,
        input  o_underrun,
        input  o_busy
    );
endinterface

// File: rtl/lvds_tx.sv
// LVDS I/Q transmitter: serializes 32-bit FIFO words MSB-first, 2 bits per DDR clock,
// on a fixed 16-cycle word cadence; idle pattern when no word was fetched.
module lvds_tx #(
    parameter bit          FORCE_SYNC = 1'b1,
    parameter logic [31:0] IDLE_WORD  = 32'h0000_0000
) (
    input  logic     i_ddr_clk,
    input  logic     i_rst_b,
    lvds_tx_if.slave tx_io
);

    localparam logic [3:0] FetchPhase = 4'd14;
    localparam logic [3:0] LoadPhase  = 4'd15;

    logic [3:0]  phase_q, phase_d;
    logic [31:0] shift_q, shift_d;
    logic        pending_q, pending_d;
    logic        strobe_q, strobe_d;
    logic        busy_q, busy_d;

    logic        fetch_point;
    logic        pull;
    logic        underrun;
    logic [31:0] load_word;

    always_comb begin
        fetch_point = (phase_q == FetchPhase);
        pull        = fetch_point & tx_io.i_tx_enable & ~tx_io.i_fifo_empty;
        underrun    = fetch_point & tx_io.i_tx_enable & tx_io.i_fifo_empty;
    end

    // Sync markers replace the top two bits of each 16-bit I and Q half.
    always_comb begin
        if (FORCE_SYNC) begin
            load_word = {2'b10, tx_io.i_fifo_data[29:16], 2'b01, tx_io.i_fifo_data[13:0]};
        end else begin
            load_word = tx_io.i_fifo_data;
        end
    end

    always_comb begin
        phase_d   = phase_q + 4'd1;
        shift_d   = {shift_q[29:0], 2'b00};
        pending_d = pending_q | pull;
        strobe_d  = 1'b0;
        busy_d    = busy_q;
        if (phase_q == LoadPhase) begin
            pending_d = 1'b0;
            if (pending_q) begin
                shift_d  = load_word;
                strobe_d = 1'b1;
                busy_d   = 1'b1;
            end else begin
                shift_d = IDLE_WORD;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            phase_q   <= 4'd0;
            shift_q   <= 32'h0000_0000;
            pending_q <= 1'b0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            shift_q   <= shift_d;
            pending_q <= pending_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        tx_io.o_ddr_data    = shift_q[31:30];
        tx_io.o_fifo_pull   = pull;
        tx_io.o_underrun    = underrun;
        tx_io.o_word_strobe = strobe_q;
        tx_io.o_busy        = busy_q;
    end

endmodule
